bit_population_counter_pipe: RTL
================================

# bit_population_counter_pipe

Pipelined, parametrised successor of the single-stage bit population counter. Counts set bits (or clear bits) of a WIDTH-bit word restricted to a per-beat bit mask, through a registered adder tree that sustains one beat per clock. Valid/ready handshakes on both sides allow back-pressure. It sits between a data producer and any statistics or threshold logic that consumes per-word counts.

## Interface
- WIDTH, 16: input word width; WIDTH/CHUNK must be a power of two, WIDTH ≥ CHUNK.
- CHUNK, 4: bits counted per first-stage chunk; WIDTH % CHUNK == 0.
- LAT (localparam): 1 + log2(WIDTH/CHUNK); pipeline latency in cycles (3 for defaults).
- OW (localparam): $clog2(WIDTH)+1; output count width.

- clk_i  input  1  single clock, all state on rising edge.
- arst_n_i  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronous to clk_i at the integration level.
- data_i  input  WIDTH  word to count.
- mask_i  input  WIDTH  1 = bit participates, 0 = bit ignored.
- mode_i  input  1  0 = count ones, 1 = count zeros (of masked-in bits).
- data_val_i  input  1  input beat valid.
- data_ready_o  output  1  block can accept a beat this cycle.
- data_o  output  OW  count for the beat at the output.
- data_val_o  output  1  data_o valid.
- data_ready_i  input  1  downstream accepts the output beat.

## Operation
- Per-bit term: b[k] = mask_i[k] & (data_i[k] ^ mode_i).
- Stage 1: WIDTH/CHUNK chunk counts, each $clog2(CHUNK)+1 bits, registered with a valid bit.
- Stages 2..LAT: pairwise adder tree; each level registered with its own valid bit; each sum widened by one bit so no overflow. Final stage width is OW; the maximum value WIDTH is representable.
- Global pipeline enable: en = !data_val_o || data_ready_i. When en = 1 every stage advances (valid bits shift, bubbles propagate as valid = 0). When en = 0 all stage registers, including data_o/data_val_o, hold.
- data_ready_o = en (combinational path from data_ready_i to data_ready_o is permitted and documented).
- Input accepted iff data_val_i && data_ready_o. When en = 1 and data_val_i = 0, a bubble enters stage 1.
- Outputs are in acceptance order; no reordering, no drop, no duplication.
- data_o is registered and holds its last value while data_val_o = 0; the consumer must ignore it then.

## Timing
- Reset (arst_n_i = 0): all valid bits 0, all count registers 0, so data_o = 0, data_val_o = 0 immediately (asynchronous), data_ready_o = 1 (since data_val_o = 0). In-flight beats are discarded; nothing is emitted after release.
- Latency: a beat accepted at edge N appears with data_val_o = 1 after edge N+LAT−1... precisely: accepted on edge t, visible on data_o/data_val_o after edge t+LAT−1 (i.e. LAT register stages including the acceptance edge), provided no stall.
- Throughput: one beat per cycle while data_ready_i = 1.
- Stall: data_val_o = 1 && data_ready_i = 0 → data_o, data_val_o stable, data_ready_o = 0, no input accepted; beats inside the pipe are frozen, not compacted.
- Simultaneous: output handshake and input accept in the same cycle are both legal; the pipe advances by one.
- data_val_o = 1 with data_ready_i = 1 completes the output beat on that edge.
- mask_i = 0 → count 0 in either mode. mode_i and mask_i are sampled with data_i; changes on non-accepted cycles have no effect.

## Test plan
- Defaults; data_i = 16'hFFFF, mask_i = 16'hFFFF, mode_i = 0, one beat, ready_i = 1 → data_val_o high for exactly one cycle, LAT = 3 edges after acceptance, data_o = 16.
- data_i = 16'hA5A5, mask_i = 16'hFFFF, mode_i = 1 → data_o = 8; data_i = 16'h00F0, mask_i = 16'h00FF, mode_i = 1 → data_o = 4; mask_i = 0, any data, both modes → data_o = 0.
- 8 back-to-back beats data_i = 16'h0001 << k (k = 0..7) with mask_i = 16'h00FF·k-dependent per a reference model, ready_i = 1 → 8 consecutive valid outputs, correct order, no gaps, data_ready_o constantly 1.
- 3 beats in flight, hold data_ready_i = 0 for 5 cycles → data_val_o = 1, data_o stable, data_ready_o = 0 throughout, input val_i held with no acceptance; release → remaining beats emerge in order, counts correct, none lost or duplicated.
- Assert arst_n_i = 0 asynchronously (mid-cycle) with 2 beats in flight → data_val_o and data_o drop to 0 before the next edge; after release, no stale beat appears, data_ready_o = 1, next accepted beat has normal LAT latency.
- Random beats with random data_ready_i (≥1000 cycles) against a scoreboard: ordered, masked, mode-correct counts; also run WIDTH = 32, CHUNK = 8 (LAT = 3, data_o = 32 for all-ones).

Source files
------------

// File: rtl/bit_population_counter_pipe.sv
// Masked set/clear bit counter with a registered chunk-then-adder-tree pipeline.
// Latency: LAT = 1 + log2(WIDTH/CHUNK) cycles from acceptance edge to data_o; one beat per clock.
// Backpressure: single global enable; a stalled output freezes every stage, data_ready_o = !data_val_o || data_ready_i.
module bit_population_counter_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic [WIDTH-1:0]           mask_i,
    input  logic                       mode_i,
    input  logic                       data_val_i,
    output logic                       data_ready_o,
    output logic [$clog2(WIDTH):0]     data_o,
    output logic                       data_val_o,
    input  logic                       data_ready_i
);

    localparam int LAT  = 1 + $clog2(WIDTH / CHUNK);
    localparam int OW   = $clog2(WIDTH) + 1;
    localparam int NCH  = WIDTH / CHUNK;
    localparam int LVLS = LAT - 1;
    localparam int CW0  = $clog2(CHUNK) + 1;

    logic             en;
    logic             out_vld;
    logic [WIDTH-1:0] bits;

    // XOR with mode turns "count zeros" into "count ones" before masking
    assign bits         = mask_i & (data_i ^ {WIDTH{mode_i}});
    assign en           = !out_vld || data_ready_i;
    assign data_ready_o = en;

    genvar l;
    generate
        for (l = 0; l <= LVLS; l++) begin : g_lvl
            localparam int NE = NCH >> l;
            localparam int CW = CW0 + l;

            logic [CW-1:0] cnt_q [NE];
            logic          vld_q;

            if (l == 0) begin : g_leaf
                logic [CW-1:0] sum [NE];

                always_comb begin
                    for (int c = 0; c < NE; c++) begin
                        sum[c] = '0;
                        for (int k = 0; k < CHUNK; k++) begin
                            sum[c] = sum[c] + CW'(bits[c*CHUNK + k]);
                        end
                    end
                end

                always_ff @(posedge clk_i or negedge arst_n_i) begin
                    if (!arst_n_i) begin
                        vld_q <= 1'b0;
                        for (int c = 0; c < NE; c++) cnt_q[c] <= '0;
                    end else if (en) begin
                        vld_q <= data_val_i;
                        if (data_val_i) begin
                            for (int c = 0; c < NE; c++) cnt_q[c] <= sum[c];
                        end
                    end
                end
            end else begin : g_node
                // Counts only load behind a valid beat, so data_o keeps its last value across bubbles
                always_ff @(posedge clk_i or negedge arst_n_i) begin
                    if (!arst_n_i) begin
                        vld_q <= 1'b0;
                        for (int i = 0; i < NE; i++) cnt_q[i] <= '0;
                    end else if (en) begin
                        vld_q <= g_lvl[l-1].vld_q;
                        if (g_lvl[l-1].vld_q) begin
                            for (int i = 0; i < NE; i++) begin
                                cnt_q[i] <= {1'b0, g_lvl[l-1].cnt_q[2*i]}
                                          + {1'b0, g_lvl[l-1].cnt_q[2*i+1]};
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_vld    = g_lvl[LVLS].vld_q;
    assign data_val_o = out_vld;
    assign data_o     = OW'(g_lvl[LVLS].cnt_q[0]);

endmodule
